// File: rtl/serv_rf_dbg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serv_rf_dbg_arb_pkg
// Brief   : Shared state encodings and RF geometry helpers for the RF debug arbiter
// Revision: 1.0 - initial release
// ============================================================================
package serv_rf_dbg_arb_pkg;

    localparam int c_GPRS = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CORE = 3'd1,
        ST_DRD  = 3'd2,
        ST_DWR  = 3'd3,
        ST_DACK = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_DBG  = 1'b1
    } grant_t;

    function automatic int rf_beats(input int width);
        return 32 / width;
    endfunction

    // Beat counter is kept at least one bit wide even when a word is a single beat.
    function automatic int rf_beat_bits(input int width);
        return (width == 32) ? 1 : $clog2(32 / width);
    endfunction

    function automatic int rf_reg_bits(input int csr_regs);
        return $clog2(c_GPRS + csr_regs);
    endfunction

    function automatic int rf_addr_bits(input int width, input int csr_regs);
        return $clog2(32 * (c_GPRS + csr_regs) / width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serv_rf_dbg_serdes.sv
`default_nettype none
// ============================================================================
// Module  : serv_rf_dbg_serdes
// Brief   : Beat counter, write-word slicer and read-word assembler for debug RF access
// Revision: 1.0 - initial release
// ============================================================================
module serv_rf_dbg_serdes
    import serv_rf_dbg_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int N     = rf_beats(WIDTH),
    localparam int BW    = rf_beat_bits(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_wstep,
    input  logic             i_rstep,
    input  logic [31:0]      i_wdata,
    input  logic [WIDTH-1:0] i_rdata,
    output logic [BW-1:0]    o_beat,
    output logic             o_last,
    output logic [WIDTH-1:0] o_wslice,
    output logic             o_rd_done,
    output logic [31:0]      o_rdata
);

    localparam logic [BW-1:0] c_LAST = BW'(N - 1);

    logic [BW-1:0] r_beat;
    logic          r_pend;
    logic [BW-1:0] r_idx;
    logic [31:0]   r_asm;
    logic [31:0]   r_rdata;
    logic [31:0]   w_asm_next;

    assign o_beat    = r_beat;
    assign o_last    = (r_beat == c_LAST);
    assign o_wslice  = i_wdata[int'(r_beat) * WIDTH +: WIDTH];
    assign o_rd_done = r_pend && (r_idx == c_LAST);
    assign o_rdata   = r_rdata;

    // RAM data for a beat arrives one cycle after its address was issued.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[int'(r_idx) * WIDTH +: WIDTH] = i_rdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beat  <= '0;
            r_pend  <= 1'b0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_rdata <= '0;
        end else begin
            if (i_clr) begin
                r_beat <= '0;
            end else if (i_wstep || i_rstep) begin
                r_beat <= o_last ? '0 : r_beat + BW'(1);
            end
            r_pend <= i_rstep;
            r_idx  <= r_beat;
            if (r_pend) begin
                r_asm <= w_asm_next;
            end
            if (o_rd_done) begin
                r_rdata <= w_asm_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serv_rf_dbg_arb.sv
`default_nettype none
// ============================================================================
// Module  : serv_rf_dbg_arb
// Brief   : Round-robin arbiter sharing the SERV RF RAM between core and debug port
// Revision: 1.0 - initial release
// ============================================================================
module serv_rf_dbg_arb
    import serv_rf_dbg_arb_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int CSR_REGS = 4,
    parameter  int CORE_WIN = 36,
    localparam int N        = rf_beats(WIDTH),
    localparam int BW       = rf_beat_bits(WIDTH),
    localparam int RW       = rf_reg_bits(CSR_REGS),
    localparam int AW       = rf_addr_bits(WIDTH, CSR_REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_core_rreq,
    input  logic             i_core_wreq,
    output logic             o_core_ready,
    output logic             o_if_rreq,
    output logic             o_if_wreq,
    input  logic             i_if_ready,
    input  logic [AW-1:0]    i_if_waddr,
    input  logic [WIDTH-1:0] i_if_wdata,
    input  logic             i_if_wen,
    input  logic [AW-1:0]    i_if_raddr,
    input  logic             i_dbg_req,
    input  logic             i_dbg_we,
    input  logic [RW-1:0]    i_dbg_reg,
    input  logic [31:0]      i_dbg_wdata,
    output logic             o_dbg_ack,
    output logic [31:0]      o_dbg_rdata,
    output logic [AW-1:0]    o_waddr,
    output logic [WIDTH-1:0] o_wdata,
    output logic             o_wen,
    output logic [AW-1:0]    o_raddr,
    input  logic [WIDTH-1:0] i_rdata
);

    localparam int            WW         = (CORE_WIN > 1) ? $clog2(CORE_WIN) : 1;
    localparam logic [WW-1:0] c_WIN_LOAD = WW'(CORE_WIN - 1);

    arb_state_t    r_state;
    arb_state_t    w_next;
    grant_t        r_last_gnt;
    grant_t        w_last_gnt_next;
    logic [WW-1:0] r_win;
    logic [WW-1:0] w_win_next;

    logic             w_core_req;
    logic             w_core_fwd;
    logic             w_rstep;
    logic             w_wstep;
    logic [BW-1:0]    w_beat;
    logic             w_last;
    logic             w_rd_done;
    logic [WIDTH-1:0] w_wslice;
    logic [AW-1:0]    w_dbg_addr;

    assign w_core_req = i_core_rreq | i_core_wreq;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_last_gnt <= GNT_DBG;
            r_win      <= '0;
        end else begin
            r_state    <= w_next;
            r_last_gnt <= w_last_gnt_next;
            r_win      <= w_win_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        w_last_gnt_next = r_last_gnt;
        w_win_next      = r_win;
        w_core_fwd      = 1'b0;
        w_rstep         = 1'b0;
        w_wstep         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_core_req && (!i_dbg_req || (r_last_gnt == GNT_DBG))) begin
                    w_core_fwd      = 1'b1;
                    w_next          = ST_CORE;
                    w_win_next      = c_WIN_LOAD;
                    w_last_gnt_next = GNT_CORE;
                end else if (i_dbg_req) begin
                    w_next = i_dbg_we ? ST_DWR : ST_DRD;
                end
            end
            ST_CORE: begin
                w_core_fwd = 1'b1;
                if (w_core_req) begin
                    w_win_next = c_WIN_LOAD;
                end else if (r_win == '0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_win_next = r_win - WW'(1);
                end
            end
            ST_DRD: begin
                // Final cycle only captures the last beat; no new address is issued.
                if (w_rd_done) begin
                    w_next = ST_DACK;
                end else begin
                    w_rstep = 1'b1;
                end
            end
            ST_DWR: begin
                w_wstep = 1'b1;
                if (w_last) begin
                    w_next = ST_DACK;
                end
            end
            ST_DACK: begin
                w_last_gnt_next = GNT_DBG;
                w_next          = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign o_if_rreq    = w_core_fwd & i_core_rreq;
    assign o_if_wreq    = w_core_fwd & i_core_wreq;
    assign o_core_ready = w_core_fwd & i_if_ready;
    assign o_dbg_ack    = (r_state == ST_DACK);

    serv_rf_dbg_serdes #(
        .WIDTH (WIDTH)
    ) u_serdes (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (r_state == ST_IDLE),
        .i_wstep   (w_wstep),
        .i_rstep   (w_rstep),
        .i_wdata   (i_dbg_wdata),
        .i_rdata   (i_rdata),
        .o_beat    (w_beat),
        .o_last    (w_last),
        .o_wslice  (w_wslice),
        .o_rd_done (w_rd_done),
        .o_rdata   (o_dbg_rdata)
    );

    generate
        if (N == 1) begin : g_addr_word
            assign w_dbg_addr = i_dbg_reg;
        end else begin : g_addr_beat
            assign w_dbg_addr = {i_dbg_reg, w_beat};
        end
    endgenerate

    // Core write enables only reach the RAM while the core owns it.
    always_comb begin
        o_raddr = i_if_raddr;
        o_waddr = i_if_waddr;
        o_wdata = i_if_wdata;
        o_wen   = 1'b0;
        case (r_state)
            ST_CORE: begin
                o_wen = i_if_wen;
            end
            ST_DRD: begin
                o_raddr = w_dbg_addr;
            end
            ST_DWR: begin
                o_waddr = w_dbg_addr;
                o_wdata = w_wslice;
                o_wen   = 1'b1;
            end
            default: begin
                o_wen = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serv_rf_dbg_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_serv_rf_dbg_arb
// Brief   : Randomized bench for serv_rf_dbg_arb with a register-level reference model
// Revision: 1.0 - initial release
// ============================================================================
module tb_serv_rf_dbg_arb;

    localparam int WIDTH    = 8;
    localparam int CSR_REGS = 4;
    localparam int CORE_WIN = 36;
    localparam int N        = 32 / WIDTH;
    localparam int NREGS    = 32 + CSR_REGS;
    localparam int RW       = $clog2(NREGS);
    localparam int AW       = $clog2(32 * NREGS / WIDTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_core_rreq, i_core_wreq, i_if_ready, i_if_wen;
    logic [AW-1:0]    i_if_waddr, i_if_raddr;
    logic [WIDTH-1:0] i_if_wdata;
    logic             i_dbg_req, i_dbg_we;
    logic [RW-1:0]    i_dbg_reg;
    logic [31:0]      i_dbg_wdata;
    logic             o_core_ready, o_if_rreq, o_if_wreq, o_dbg_ack, o_wen;
    logic [31:0]      o_dbg_rdata;
    logic [AW-1:0]    o_waddr, o_raddr;
    logic [WIDTH-1:0] o_wdata;
    logic [WIDTH-1:0] ram_q;

    logic [WIDTH-1:0] ram [0:(1<<AW)-1];
    logic [31:0]      mdl [0:NREGS-1];
    bit               known [0:NREGS-1];
    bit               lg_dbg;
    logic [31:0]      last_rd;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_err = 0;

    serv_rf_dbg_arb #(
        .WIDTH    (WIDTH),
        .CSR_REGS (CSR_REGS),
        .CORE_WIN (CORE_WIN)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_core_rreq  (i_core_rreq),
        .i_core_wreq  (i_core_wreq),
        .o_core_ready (o_core_ready),
        .o_if_rreq    (o_if_rreq),
        .o_if_wreq    (o_if_wreq),
        .i_if_ready   (i_if_ready),
        .i_if_waddr   (i_if_waddr),
        .i_if_wdata   (i_if_wdata),
        .i_if_wen     (i_if_wen),
        .i_if_raddr   (i_if_raddr),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_we     (i_dbg_we),
        .i_dbg_reg    (i_dbg_reg),
        .i_dbg_wdata  (i_dbg_wdata),
        .o_dbg_ack    (o_dbg_ack),
        .o_dbg_rdata  (o_dbg_rdata),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_wen        (o_wen),
        .o_raddr      (o_raddr),
        .i_rdata      (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_wen) ram[o_waddr] <= o_wdata;
        ram_q <= ram[o_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ram_word(input int r);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < N; k++) w[k*WIDTH +: WIDTH] = ram[r*N + k];
        return w;
    endfunction

    // One debug access; c1/c2 are cycle offsets of core rreq pulses (-1 = none).
    task automatic do_op(input bit we, input int rg, input logic [31:0] wd,
                         input int c1, input int c2);
        int t0, t_ack, t_f1, t_f2, base, e_ack, e_f1;
        bit ga, gf1, gf2, fwd_now, wen_bad, rdy_bad;
        logic [31:0] rd;
        base = we ? N + 1 : N + 2;
        ga = 0; gf1 = (c1 < 0); gf2 = (c2 < 0);
        wen_bad = 0; rdy_bad = 0; rd = '0;
        t_ack = -1; t_f1 = -1; t_f2 = -1; e_f1 = -1;
        @(posedge clk); #1;
        t0 = cyc;
        i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_reg = RW'(rg); i_dbg_wdata = wd;
        for (int i = 0; i < 400 && !(ga && gf1 && gf2); i++) begin
            if (c1 >= 0 && cyc - t0 == c1) i_core_rreq = 1'b1;
            if (c2 >= 0 && cyc - t0 == c2) i_core_rreq = 1'b1;
            if (c1 > 0 && !ga && i_core_rreq && !gf1) begin
                i_if_wen   = 1'b1;
                i_if_waddr = AW'($urandom);
                i_if_wdata = WIDTH'($urandom);
            end
            @(negedge clk);
            if (!we && o_wen) wen_bad = 1;
            if (i_core_rreq && !o_if_rreq && o_core_ready) rdy_bad = 1;
            if (o_if_rreq && !o_core_ready) rdy_bad = 1;
            fwd_now = o_if_rreq;
            if (fwd_now) begin
                if (!gf1) begin gf1 = 1; t_f1 = cyc - t0; end
                else if (!gf2) begin gf2 = 1; t_f2 = cyc - t0; end
            end
            if (o_dbg_ack && !ga) begin ga = 1; t_ack = cyc - t0; rd = o_dbg_rdata; end
            @(posedge clk); #1;
            if (fwd_now) i_core_rreq = 1'b0;
            if (ga) begin i_dbg_req = 1'b0; i_if_wen = 1'b0; end
        end
        if (c1 < 0) begin
            e_ack = base;
        end else if (c1 == 0 && lg_dbg) begin
            e_f1  = 0;
            e_ack = ((c2 >= 0) ? c2 : 0) + CORE_WIN + 1 + base;
        end else begin
            e_ack = base;
            e_f1  = base + 1;
        end
        chk("ack_seen", 32'(ga), 32'd1);
        chk("ack_lat", t_ack, e_ack);
        if (c1 >= 0) chk("fwd_lat", t_f1, e_f1);
        if (c2 >= 0) chk("fwd2_lat", t_f2, c2);
        chk("core_rdy", 32'(rdy_bad), 32'd0);
        if (!we) begin
            chk("rd_wen", 32'(wen_bad), 32'd0);
            if (known[rg]) chk("rdata", rd, mdl[rg]);
            last_rd = rd;
        end else begin
            chk("rd_hold", rd, last_rd);
            mdl[rg]   = wd;
            known[rg] = 1;
        end
        lg_dbg = !(c1 >= 0 && e_f1 > e_ack);
        if (c1 >= 0) repeat (CORE_WIN + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        int rg;
        int t0;
        for (int a = 0; a < (1 << AW); a++) ram[a] = WIDTH'($urandom);
        for (int r = 0; r < NREGS; r++) begin known[r] = 0; mdl[r] = '0; end
        lg_dbg = 1; last_rd = '0;
        rst = 1'b1;
        i_core_rreq = 0; i_core_wreq = 0; i_if_ready = 1; i_if_wen = 0;
        i_if_waddr = '0; i_if_raddr = '0; i_if_wdata = '0;
        i_dbg_req = 0; i_dbg_we = 0; i_dbg_reg = '0; i_dbg_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(o_dbg_ack), 32'd0);
        chk("rst_wen", 32'(o_wen), 32'd0);
        chk("rst_rdata", o_dbg_rdata, 32'd0);
        chk("rst_rreq", 32'(o_if_rreq), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Core and debug collide straight out of reset: core wins first.
        do_op(1, 3, 32'h1234_5678, 0, -1);

        do_op(1, 5, 32'hDEAD_BEEF, -1, -1);
        chk("ram5_b0", 32'(ram[5*N + 0]), 32'hEF);
        chk("ram5_b1", 32'(ram[5*N + 1]), 32'hBE);
        chk("ram5_b2", 32'(ram[5*N + 2]), 32'hAD);
        chk("ram5_b3", 32'(ram[5*N + 3]), 32'hDE);
        do_op(0, 5, '0, -1, -1);

        // Core arrives mid-read with a stray write enable that must not land.
        do_op(0, 3, '0, 2, -1);
        do_op(1, 7, 32'hA5C3_0F96, -1, -1);
        // Second core request inside the window pushes the debug grant out.
        do_op(0, 7, '0, 0, 10);

        for (int it = 0; it < 40; it++) begin
            bit we;
            int c1;
            we = ($urandom_range(0, 1) == 1);
            c1 = ($urandom_range(0, 3) == 0) ? 0 : -1;
            if (we) begin
                rg = $urandom_range(0, NREGS - 1);
            end else begin
                rg = $urandom_range(0, NREGS - 1);
                while (!known[rg]) rg = $urandom_range(0, NREGS - 1);
            end
            do_op(we, rg, $urandom, c1, -1);
        end

        // Reset asserted during the third beat of a debug write.
        @(posedge clk); #1;
        t0 = cyc;
        i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = RW'(9); i_dbg_wdata = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1;
        chk("dwr_cycle", cyc - t0, 32'd3);
        chk("wen_pre_rst", 32'(o_wen), 32'd1);
        chk("waddr_b2", 32'(o_waddr), 32'(9*N + 2));
        rst = 1'b1;
        #1;
        chk("rst_mid_wen", 32'(o_wen), 32'd0);
        chk("rst_mid_ack", 32'(o_dbg_ack), 32'd0);
        i_dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_rdata", o_dbg_rdata, 32'd0);
        known[9] = 0; last_rd = '0; lg_dbg = 1;
        do_op(1, 9, 32'h600D_CAFE, -1, -1);
        do_op(0, 9, '0, -1, -1);

        for (int r = 0; r < NREGS; r++) begin
            if (known[r]) chk("ram_sweep", ram_word(r), mdl[r]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
